// File: rtl/am2950_pkg.sv
// am2950_pkg: shared definitions for the am2950 bus port controller.
//   - tx_state_e  : transmit FSM state encoding (IDLE/SETUP/STROBE/WAIT)
//   - AM2950_WIDTH: default data path width
package am2950_pkg;

    localparam int AM2950_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/am2950_flag.sv
// am2950_flag: single status flag flip-flop.
//   clk   : clock
//   rst_  : asynchronous active-low clear
//   i_set : synchronous set
//   i_clr : synchronous clear (wins over i_set)
//   o_q   : flag value
module am2950_flag (
    input  logic clk,
    input  logic rst_,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    // Flag state: clear has priority over set.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/am2950.sv
// am2950: bidirectional bus port controller with strobe/acknowledge handshake,
// feeding an am2926 inverting bus driver/receiver.
//
// Optional feature macro: AM2950_OVERRUN_EN adds the sticky receive-overrun
// output `ovr`; without it rejected strobes are silently dropped.
//
// Ports:
//   clk, rst_      : clock, asynchronous active-low reset
//   a_d, ldr, fr   : local transmit data, load strobe, R-full flag
//   s_q, rds, fs   : received word, local read (clears fs), S-full flag
//   d, be, re_     : to am2926 (driver data = R, drive enable, receive enable)
//   r              : from am2926 receiver
//   bstb_, back_   : outgoing strobe / partner acknowledge (active low)
//   bin_stb_, bin_ack_ : incoming strobe / our acknowledge (active low)
//   ovr            : receive overrun (AM2950_OVERRUN_EN only)
module am2950
    import am2950_pkg::*;
#(
    parameter int WIDTH = AM2950_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] a_d,
    input  logic             ldr,
    output logic             fr,
    output logic [WIDTH-1:0] s_q,
    input  logic             rds,
    output logic             fs,
    output logic [WIDTH-1:0] d,
    output logic             be,
    output logic             re_,
    input  logic [WIDTH-1:0] r,
    output logic             bstb_,
    input  logic             back_,
    input  logic             bin_stb_,
    output logic             bin_ack_
`ifdef AM2950_OVERRUN_EN
    ,
    output logic             ovr
`endif
);

    tx_state_e        r_state;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_s;
    logic             r_be;
    logic             r_bstb_n;
    logic             r_bin_ack_n;
    logic             r_stb_prev;

    logic w_fr;
    logic w_fs;
    logic w_load;
    logic w_fr_clr;
    logic w_stb_new;
    logic w_accept;

    // A load is taken only from IDLE with R empty; otherwise R is left alone.
    assign w_load   = (r_state == ST_IDLE) && ldr && !w_fr;
    assign w_fr_clr = (r_state == ST_WAIT) && !back_;

    // Incoming strobe counts once per falling edge, and only while listening.
    assign w_stb_new = !r_be && !bin_stb_ && r_stb_prev;
    assign w_accept  = w_stb_new && !w_fs;

    // Transmit FSM with registered be/bstb_ derived from the next state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= ST_IDLE;
            r_r      <= '0;
            r_be     <= 1'b0;
            r_bstb_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state  <= ST_SETUP;
                        r_r      <= a_d;
                        r_be     <= 1'b1;
                        r_bstb_n <= 1'b1;
                    end else begin
                        r_be     <= 1'b0;
                        r_bstb_n <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state  <= ST_STROBE;
                    r_be     <= 1'b1;
                    r_bstb_n <= 1'b0;
                end
                ST_STROBE: begin
                    r_state  <= ST_WAIT;
                    r_be     <= 1'b1;
                    r_bstb_n <= 1'b1;
                end
                ST_WAIT: begin
                    // No timeout: the partner's acknowledge is the only exit.
                    if (!back_) begin
                        r_state  <= ST_IDLE;
                        r_be     <= 1'b0;
                    end else begin
                        r_be     <= 1'b1;
                    end
                    r_bstb_n <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_be     <= 1'b0;
                    r_bstb_n <= 1'b1;
                end
            endcase
        end
    end

    // Receive path: S capture, one-cycle acknowledge, strobe history.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_s         <= '0;
            r_bin_ack_n <= 1'b1;
            r_stb_prev  <= 1'b1;
        end else begin
            r_stb_prev  <= bin_stb_;
            r_bin_ack_n <= !w_accept;
            if (w_accept) begin
                r_s <= r;
            end else begin
                r_s <= r_s;
            end
        end
    end

    am2950_flag u_fr (
        .clk   (clk),
        .rst_  (rst_),
        .i_set (w_load),
        .i_clr (w_fr_clr),
        .o_q   (w_fr)
    );

    am2950_flag u_fs (
        .clk   (clk),
        .rst_  (rst_),
        .i_set (w_accept),
        .i_clr (rds),
        .o_q   (w_fs)
    );

`ifdef AM2950_OVERRUN_EN
    logic w_reject;
    logic w_ovr_clr;

    assign w_reject  = w_stb_new && w_fs;
    // A rejection in the same cycle as rds must leave the overrun visible.
    assign w_ovr_clr = rds && !w_reject;

    am2950_flag u_ovr (
        .clk   (clk),
        .rst_  (rst_),
        .i_set (w_reject),
        .i_clr (w_ovr_clr),
        .o_q   (ovr)
    );
`endif

    assign fr       = w_fr;
    assign fs       = w_fs;
    assign s_q      = r_s;
    assign d        = r_r;
    assign be       = r_be;
    assign re_      = r_be;
    assign bstb_    = r_bstb_n;
    assign bin_ack_ = r_bin_ack_n;

endmodule

// File: tb/tb_am2950.sv
module tb_am2950;

    logic       clk;
    logic       rst_;
    logic [7:0] a_d;
    logic       ldr;
    logic       fr;
    logic [7:0] s_q;
    logic       rds;
    logic       fs;
    logic [7:0] d;
    logic       be;
    logic       re_;
    logic [7:0] r;
    logic       bstb_;
    logic       back_;
    logic       bin_stb_;
    logic       bin_ack_;
`ifdef AM2950_OVERRUN_EN
    logic       ovr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    am2950 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .a_d      (a_d),
        .ldr      (ldr),
        .fr       (fr),
        .s_q      (s_q),
        .rds      (rds),
        .fs       (fs),
        .d        (d),
        .be       (be),
        .re_      (re_),
        .r        (r),
        .bstb_    (bstb_),
        .back_    (back_),
        .bin_stb_ (bin_stb_),
        .bin_ack_ (bin_ack_)
`ifdef AM2950_OVERRUN_EN
        ,
        .ovr      (ovr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every outgoing strobe and every incoming ack is matched
    // against the scoreboard queues.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_ && !bstb_) begin
            if (exp_tx.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: strobe with d=%0h, expected no strobe", d);
            end else begin
                e = exp_tx.pop_front();
                chk("tx_d", 32'(d), 32'(e));
                chk("tx_be", 32'(be), 32'd1);
                chk("tx_re_", 32'(re_), 32'd1);
            end
        end
        if (rst_ && !bin_ack_) begin
            if (exp_rx.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: ack with s_q=%0h, expected no ack", s_q);
            end else begin
                e = exp_rx.pop_front();
                chk("rx_s_q", 32'(s_q), 32'(e));
                chk("rx_fs", 32'(fs), 32'd1);
            end
        end
    end

    initial begin
        rst_     = 1'b0;
        a_d      = 8'h00;
        ldr      = 1'b0;
        rds      = 1'b0;
        r        = 8'h00;
        back_    = 1'b1;
        bin_stb_ = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_fr", 32'(fr), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_be", 32'(be), 32'd0);
        chk("rst_re_", 32'(re_), 32'd0);
        chk("rst_bstb_", 32'(bstb_), 32'd1);
        chk("rst_bin_ack_", 32'(bin_ack_), 32'd1);
        chk("rst_d", 32'(d), 32'h00);
        chk("rst_s_q", 32'(s_q), 32'h00);
`ifdef AM2950_OVERRUN_EN
        chk("rst_ovr", 32'(ovr), 32'd0);
`endif
        rst_ = 1'b1;
        tick();

        // Transmit A5
        a_d = 8'hA5; ldr = 1'b1; exp_tx.push_back(8'hA5);
        tick();                                   // SETUP
        chk("tx_setup_fr", 32'(fr), 32'd1);
        chk("tx_setup_be", 32'(be), 32'd1);
        chk("tx_setup_re_", 32'(re_), 32'd1);
        chk("tx_setup_bstb_", 32'(bstb_), 32'd1);
        chk("tx_setup_d", 32'(d), 32'hA5);
        a_d = 8'h3C; ldr = 1'b1;                  // rejected load
        tick();                                   // STROBE
        ldr = 1'b0;
        chk("tx_strobe_bstb_", 32'(bstb_), 32'd0);
        chk("rej_load_d", 32'(d), 32'hA5);
        tick();                                   // WAIT
        chk("tx_wait_bstb_", 32'(bstb_), 32'd1);
        chk("tx_wait_be", 32'(be), 32'd1);
        tick();                                   // still WAIT
        chk("tx_hold_fr", 32'(fr), 32'd1);
        chk("tx_hold_d", 32'(d), 32'hA5);
        r = 8'h77; bin_stb_ = 1'b0;               // contention
        tick();
        chk("cont_fs", 32'(fs), 32'd0);
        chk("cont_re_", 32'(re_), 32'd1);
        chk("cont_ack", 32'(bin_ack_), 32'd1);
        bin_stb_ = 1'b1; back_ = 1'b0;
        tick();                                   // back to IDLE
        back_ = 1'b1;
        chk("tx_done_fr", 32'(fr), 32'd0);
        chk("tx_done_be", 32'(be), 32'd0);
        chk("tx_done_re_", 32'(re_), 32'd0);
        chk("cont_s_q", 32'(s_q), 32'h00);

        // Receive 5A
        r = 8'h5A; bin_stb_ = 1'b0; exp_rx.push_back(8'h5A);
        tick();
        bin_stb_ = 1'b1;
        chk("rx1_fs", 32'(fs), 32'd1);
        chk("rx1_ack", 32'(bin_ack_), 32'd0);
        tick();
        chk("rx1_ack_end", 32'(bin_ack_), 32'd1);
        chk("rx1_fs_hold", 32'(fs), 32'd1);

        // Strobe while full: rejected
        r = 8'hFF; bin_stb_ = 1'b0;
        tick();
        bin_stb_ = 1'b1;
        chk("ovr_s_q", 32'(s_q), 32'h5A);
        chk("ovr_ack", 32'(bin_ack_), 32'd1);
`ifdef AM2950_OVERRUN_EN
        chk("ovr_set", 32'(ovr), 32'd1);
`endif
        rds = 1'b1;
        tick();
        rds = 1'b0;
        chk("rds_fs", 32'(fs), 32'd0);
`ifdef AM2950_OVERRUN_EN
        chk("rds_ovr", 32'(ovr), 32'd0);
`endif

        // Rejection coinciding with rds
        r = 8'h11; bin_stb_ = 1'b0; exp_rx.push_back(8'h11);
        tick();
        bin_stb_ = 1'b1;
        tick();
        r = 8'h22; bin_stb_ = 1'b0;
        tick();
        bin_stb_ = 1'b1;
        tick();
        r = 8'h33; bin_stb_ = 1'b0; rds = 1'b1;
        tick();
        bin_stb_ = 1'b1; rds = 1'b0;
        chk("coinc_fs", 32'(fs), 32'd0);
        chk("coinc_s_q", 32'(s_q), 32'h11);
        chk("coinc_ack", 32'(bin_ack_), 32'd1);
`ifdef AM2950_OVERRUN_EN
        chk("coinc_ovr", 32'(ovr), 32'd1);
        rds = 1'b1;
        tick();
        rds = 1'b0;
        chk("coinc_ovr_clr", 32'(ovr), 32'd0);
`endif
        tick();

        // Held strobe is taken only once
        r = 8'h44; bin_stb_ = 1'b0; exp_rx.push_back(8'h44);
        tick();
        chk("held_fs", 32'(fs), 32'd1);
        rds = 1'b1; r = 8'h55;
        tick();
        rds = 1'b0;
        chk("held_rds_fs", 32'(fs), 32'd0);
        tick();
        chk("held_no_retake_fs", 32'(fs), 32'd0);
        chk("held_no_retake_s_q", 32'(s_q), 32'h44);
        bin_stb_ = 1'b1;
        tick();

        // Reset asserted mid-WAIT
        a_d = 8'hC3; ldr = 1'b1; exp_tx.push_back(8'hC3);
        tick();
        ldr = 1'b0;
        tick();
        tick();                                   // WAIT
        chk("mid_wait_be", 32'(be), 32'd1);
        rst_ = 1'b0;
        #1;
        chk("async_be", 32'(be), 32'd0);
        chk("async_re_", 32'(re_), 32'd0);
        tick();
        rst_ = 1'b1;
        tick();
        chk("post_rst_fr", 32'(fr), 32'd0);
        chk("post_rst_fs", 32'(fs), 32'd0);
        chk("post_rst_re_", 32'(re_), 32'd0);
        chk("post_rst_bstb_", 32'(bstb_), 32'd1);
        chk("post_rst_d", 32'(d), 32'h00);

        // Back-to-back transmits
        a_d = 8'h69; ldr = 1'b1; exp_tx.push_back(8'h69);
        tick();
        ldr = 1'b0;
        tick();
        tick();
        back_ = 1'b0;
        tick();
        back_ = 1'b1;
        chk("b2b_fr_low", 32'(fr), 32'd0);
        a_d = 8'h96; ldr = 1'b1; exp_tx.push_back(8'h96);
        tick();
        ldr = 1'b0;
        chk("b2b_fr", 32'(fr), 32'd1);
        chk("b2b_d", 32'(d), 32'h96);
        tick();
        tick();
        back_ = 1'b0;
        tick();
        back_ = 1'b1;
        chk("b2b_done_fr", 32'(fr), 32'd0);
        tick();

        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("rx_queue_empty", 32'(exp_rx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
